// File: rtl/arcade_input_pkg.sv
// Shared constants and types for the arcade input mapper.
// Holds PS/2 scancodes, joystick bit positions, key-state register indices,
// the per-player control struct and the scancode lookup helper.
package arcade_input_pkg;

  // Joystick word bit positions (per player, 16-bit word)
  localparam int unsigned JOY_RIGHT = 0;
  localparam int unsigned JOY_LEFT  = 1;
  localparam int unsigned JOY_DOWN  = 2;
  localparam int unsigned JOY_UP    = 3;
  localparam int unsigned JOY_FIRE  = 4;
  localparam int unsigned JOY_START = 5;
  localparam int unsigned JOY_COIN  = 6;

  // Player 0 scancodes (directions accept either extended or plain codes)
  localparam logic [7:0] SC_P0_UP      = 8'h75;
  localparam logic [7:0] SC_P0_DOWN    = 8'h72;
  localparam logic [7:0] SC_P0_LEFT    = 8'h6B;
  localparam logic [7:0] SC_P0_RIGHT   = 8'h74;
  localparam logic [7:0] SC_P0_FIRE_A  = 8'h29;
  localparam logic [7:0] SC_P0_FIRE_B  = 8'h14;
  localparam logic [7:0] SC_P0_START_A = 8'h16;
  localparam logic [7:0] SC_P0_START_B = 8'h05;
  localparam logic [7:0] SC_P0_COIN    = 8'h2E;

  // Player 1 scancodes (plain codes only)
  localparam logic [7:0] SC_P1_UP      = 8'h2D;
  localparam logic [7:0] SC_P1_DOWN    = 8'h2B;
  localparam logic [7:0] SC_P1_LEFT    = 8'h23;
  localparam logic [7:0] SC_P1_RIGHT   = 8'h34;
  localparam logic [7:0] SC_P1_FIRE    = 8'h1C;
  localparam logic [7:0] SC_P1_START_A = 8'h1E;
  localparam logic [7:0] SC_P1_START_B = 8'h06;
  localparam logic [7:0] SC_P1_COIN    = 8'h36;

  // Key-state register indices; keys sharing a control get separate slots
  localparam int unsigned KEY_COUNT  = 17;
  localparam int unsigned KEY_IDX_W  = 5;
  localparam int unsigned K0_UP      = 0;
  localparam int unsigned K0_DOWN    = 1;
  localparam int unsigned K0_LEFT    = 2;
  localparam int unsigned K0_RIGHT   = 3;
  localparam int unsigned K0_FIRE_A  = 4;
  localparam int unsigned K0_FIRE_B  = 5;
  localparam int unsigned K0_START_A = 6;
  localparam int unsigned K0_START_B = 7;
  localparam int unsigned K0_COIN    = 8;
  localparam int unsigned K1_UP      = 9;
  localparam int unsigned K1_DOWN    = 10;
  localparam int unsigned K1_LEFT    = 11;
  localparam int unsigned K1_RIGHT   = 12;
  localparam int unsigned K1_FIRE    = 13;
  localparam int unsigned K1_START_A = 14;
  localparam int unsigned K1_START_B = 15;
  localparam int unsigned K1_COIN    = 16;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic fire;
    logic start;
    logic coin;
  } ctrl_t;

  typedef struct packed {
    logic                 hit;
    logic [KEY_IDX_W-1:0] idx;
  } key_sel_t;

  // Map a scancode to its key-state slot; hit=0 for unmapped codes
  function automatic key_sel_t key_lookup(input logic ext, input logic [7:0] code);
    key_sel_t sel;
    sel.hit = 1'b0;
    sel.idx = '0;
    case (code)
      SC_P0_UP:      begin sel.idx = KEY_IDX_W'(K0_UP);      sel.hit = 1'b1; end
      SC_P0_DOWN:    begin sel.idx = KEY_IDX_W'(K0_DOWN);    sel.hit = 1'b1; end
      SC_P0_LEFT:    begin sel.idx = KEY_IDX_W'(K0_LEFT);    sel.hit = 1'b1; end
      SC_P0_RIGHT:   begin sel.idx = KEY_IDX_W'(K0_RIGHT);   sel.hit = 1'b1; end
      SC_P0_FIRE_A:  begin sel.idx = KEY_IDX_W'(K0_FIRE_A);  sel.hit = ~ext; end
      SC_P0_FIRE_B:  begin sel.idx = KEY_IDX_W'(K0_FIRE_B);  sel.hit = ~ext; end
      SC_P0_START_A: begin sel.idx = KEY_IDX_W'(K0_START_A); sel.hit = ~ext; end
      SC_P0_START_B: begin sel.idx = KEY_IDX_W'(K0_START_B); sel.hit = ~ext; end
      SC_P0_COIN:    begin sel.idx = KEY_IDX_W'(K0_COIN);    sel.hit = ~ext; end
      SC_P1_UP:      begin sel.idx = KEY_IDX_W'(K1_UP);      sel.hit = ~ext; end
      SC_P1_DOWN:    begin sel.idx = KEY_IDX_W'(K1_DOWN);    sel.hit = ~ext; end
      SC_P1_LEFT:    begin sel.idx = KEY_IDX_W'(K1_LEFT);    sel.hit = ~ext; end
      SC_P1_RIGHT:   begin sel.idx = KEY_IDX_W'(K1_RIGHT);   sel.hit = ~ext; end
      SC_P1_FIRE:    begin sel.idx = KEY_IDX_W'(K1_FIRE);    sel.hit = ~ext; end
      SC_P1_START_A: begin sel.idx = KEY_IDX_W'(K1_START_A); sel.hit = ~ext; end
      SC_P1_START_B: begin sel.idx = KEY_IDX_W'(K1_START_B); sel.hit = ~ext; end
      SC_P1_COIN:    begin sel.idx = KEY_IDX_W'(K1_COIN);    sel.hit = ~ext; end
      default:       begin sel.idx = '0;                     sel.hit = 1'b0; end
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/coin_pulse_stretcher.sv
// Turns a rising edge of a raw coin signal into a fixed-width pulse.
// Ports: clk_sys/reset_n clock and async active-low reset; raw coin level in;
// pulse out, high for WIDTH_CYCLES cycles per accepted edge.
module coin_pulse_stretcher #(
  parameter int unsigned WIDTH_CYCLES = 1200000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CW = $clog2(WIDTH_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          raw_q;

  // Load only on a fresh edge while idle; edges inside a pulse are dropped
  always_comb begin
    cnt_next = cnt;
    if (raw && !raw_q && (cnt == '0)) begin
      cnt_next = CW'(WIDTH_CYCLES);
    end else if (cnt != '0) begin
      cnt_next = cnt - CW'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      raw_q <= 1'b0;
      pulse <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      raw_q <= raw;
      pulse <= (cnt_next != '0);
    end
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// Maps hps_io PS/2 key events and joystick words to registered arcade controls.
// Ports: clk_sys, reset_n (async active-low); ps2_key event word; joystick
// (16 bits per player); rotate; autofire_en per player; outputs up/down/left/
// right/fire/start/coin, one bit per player.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS       = 2,
  parameter int unsigned COIN_PULSE_CYCLES = 1200000,
  parameter int unsigned AUTOFIRE_DIV      = 200000,
  parameter int unsigned SOCD_CLEAN        = 1
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic [10:0]               ps2_key,
  input  logic [16*NUM_PLAYERS-1:0] joystick,
  input  logic                      rotate,
  input  logic [NUM_PLAYERS-1:0]    autofire_en,
  output logic [NUM_PLAYERS-1:0]    up,
  output logic [NUM_PLAYERS-1:0]    down,
  output logic [NUM_PLAYERS-1:0]    left,
  output logic [NUM_PLAYERS-1:0]    right,
  output logic [NUM_PLAYERS-1:0]    fire,
  output logic [NUM_PLAYERS-1:0]    start,
  output logic [NUM_PLAYERS-1:0]    coin
);

  localparam int unsigned AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;

  logic                 tog_q;
  logic                 armed;
  logic [KEY_COUNT-1:0] keys;
  key_sel_t             sel;
  logic                 ps2_event;
  logic [AW-1:0]        af_div;
  logic                 af_phase;

  assign sel       = key_lookup(ps2_key[8], ps2_key[7:0]);
  assign ps2_event = armed && (ps2_key[10] != tog_q);

  // PS/2 event capture; first cycle after reset only samples the toggle
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q <= 1'b0;
      armed <= 1'b0;
      keys  <= '0;
    end else if (!armed) begin
      tog_q <= ps2_key[10];
      armed <= 1'b1;
    end else if (ps2_event) begin
      tog_q <= ps2_key[10];
      if (sel.hit) keys[sel.idx] <= ps2_key[9];
    end
  end

  // Free-running autofire phase generator shared by all players
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_div   <= '0;
      af_phase <= 1'b1;
    end else if (af_div == AW'(AUTOFIRE_DIV - 1)) begin
      af_div   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_div <= af_div + AW'(1);
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [15:0] joy;
    logic        unused_joy;
    ctrl_t       kb;
    ctrl_t       raw;
    ctrl_t       nxt;
    logic [5:0]  ctrl_q;

    assign joy        = joystick[16*p +: 16];
    assign unused_joy = ^joy[15:7];

    // Keyboard terms; only players 0 and 1 have key bindings
    always_comb begin
      kb = '0;
      if (p == 0) begin
        kb.up    = keys[K0_UP];
        kb.down  = keys[K0_DOWN];
        kb.left  = keys[K0_LEFT];
        kb.right = keys[K0_RIGHT];
        kb.fire  = keys[K0_FIRE_A] | keys[K0_FIRE_B];
        kb.start = keys[K0_START_A] | keys[K0_START_B];
        kb.coin  = keys[K0_COIN];
      end else if (p == 1) begin
        kb.up    = keys[K1_UP];
        kb.down  = keys[K1_DOWN];
        kb.left  = keys[K1_LEFT];
        kb.right = keys[K1_RIGHT];
        kb.fire  = keys[K1_FIRE];
        kb.start = keys[K1_START_A] | keys[K1_START_B];
        kb.coin  = keys[K1_COIN];
      end
    end

    // Merge, rotate, then clean opposing directions
    always_comb begin
      raw.up    = kb.up    | joy[JOY_UP];
      raw.down  = kb.down  | joy[JOY_DOWN];
      raw.left  = kb.left  | joy[JOY_LEFT];
      raw.right = kb.right | joy[JOY_RIGHT];
      raw.fire  = kb.fire  | joy[JOY_FIRE];
      raw.start = kb.start | joy[JOY_START];
      raw.coin  = kb.coin  | joy[JOY_COIN];

      nxt = raw;
      if (rotate) begin
        nxt.up    = raw.left;
        nxt.down  = raw.right;
        nxt.left  = raw.down;
        nxt.right = raw.up;
      end
      if (SOCD_CLEAN != 0) begin
        if (nxt.up && nxt.down) begin
          nxt.up   = 1'b0;
          nxt.down = 1'b0;
        end
        if (nxt.left && nxt.right) begin
          nxt.left  = 1'b0;
          nxt.right = 1'b0;
        end
      end
      nxt.fire = raw.fire & (autofire_en[p] ? af_phase : 1'b1);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        ctrl_q <= '0;
      end else begin
        ctrl_q <= {nxt.up, nxt.down, nxt.left, nxt.right, nxt.fire, nxt.start};
      end
    end

    assign up[p]    = ctrl_q[5];
    assign down[p]  = ctrl_q[4];
    assign left[p]  = ctrl_q[3];
    assign right[p] = ctrl_q[2];
    assign fire[p]  = ctrl_q[1];
    assign start[p] = ctrl_q[0];

    coin_pulse_stretcher #(
      .WIDTH_CYCLES(COIN_PULSE_CYCLES)
    ) u_coin (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .raw    (raw.coin),
      .pulse  (coin[p])
    );
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Scoreboard bench for arcade_input_mapper: stimulus queues expected output
// vectors tagged with a cycle number; a monitor checks them as cycles pass.
module tb_arcade_input_mapper;

  localparam int unsigned NP = 2;
  localparam int unsigned CP = 8;
  localparam int unsigned AD = 4;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic [10:0]   ps2_key;
  logic [31:0]   joystick;
  logic          rotate;
  logic [NP-1:0] autofire_en;
  logic [NP-1:0] up, down, left, right, fire, start, coin;

  arcade_input_mapper #(
    .NUM_PLAYERS      (NP),
    .COIN_PULSE_CYCLES(CP),
    .AUTOFIRE_DIV     (AD),
    .SOCD_CLEAN       (1)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_key    (ps2_key),
    .joystick   (joystick),
    .rotate     (rotate),
    .autofire_en(autofire_en),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .fire       (fire),
    .start      (start),
    .coin       (coin)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned cyc = 0;
  always @(posedge clk_sys) if (reset_n) cyc <= cyc + 1;

  int          errors = 0;
  int          checks = 0;
  int unsigned q_cyc[$];
  logic [13:0] q_vec[$];
  string       q_name[$];
  logic [13:0] act;
  logic        tog;

  assign act = {up, down, left, right, fire, start, coin};

  function automatic logic [13:0] mk(input logic [1:0] u, input logic [1:0] d,
                                      input logic [1:0] l, input logic [1:0] r,
                                      input logic [1:0] f, input logic [1:0] s,
                                      input logic [1:0] c);
    return {u, d, l, r, f, s, c};
  endfunction

  // Autofire phase after m clock edges out of reset
  function automatic logic phase_after(input int unsigned m);
    return (((m / AD) % 2) == 0);
  endfunction

  task automatic push(input int unsigned at, input logic [13:0] v, input string n);
    q_cyc.push_back(at);
    q_vec.push_back(v);
    q_name.push_back(n);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic ps2_ev(input logic pressed, input logic ext, input logic [7:0] code);
    tog     = ~tog;
    ps2_key = {tog, pressed, ext, code};
  endtask

  // Monitor: compare every queued expectation whose cycle has arrived
  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      while (q_cyc.size() != 0 && q_cyc[0] <= cyc) begin
        int unsigned at;
        logic [13:0] v;
        string       n;
        at = q_cyc.pop_front();
        v  = q_vec.pop_front();
        n  = q_name.pop_front();
        checks++;
        if (at != cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d missed (now %0d)", n, at, cyc);
        end else if (act !== v) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %b want %b (u,d,l,r,f,s,c)", n, cyc, act, v);
        end
      end
    end
  end

  initial begin
    int unsigned c;
    tog         = 1'b1;
    ps2_key     = {1'b1, 1'b1, 1'b0, 8'h75};
    joystick    = '0;
    rotate      = 1'b0;
    autofire_en = '0;

    push(0, '0, "reset_state");
    tick(3);
    reset_n = 1'b1;

    // Arming cycle must not treat the held toggle as an event
    c = cyc;
    for (int k = 1; k <= 4; k++) push(c + k, '0, "no_event_after_arm");
    tick(5);

    // Extended up-arrow press and release, 2-cycle latency
    c = cyc;
    ps2_ev(1'b1, 1'b1, 8'h75);
    push(c + 1, '0, "kb_up_lat1");
    push(c + 2, mk(2'b01, 0, 0, 0, 0, 0, 0), "kb_up_lat2");
    tick(3);
    c = cyc;
    ps2_ev(1'b0, 1'b1, 8'h75);
    push(c + 1, mk(2'b01, 0, 0, 0, 0, 0, 0), "kb_up_hold");
    push(c + 2, '0, "kb_up_release");
    tick(3);

    // Rotation then SOCD on the rotated result
    c = cyc;
    rotate      = 1'b1;
    joystick[1] = 1'b1;
    push(c + 1, mk(2'b01, 0, 0, 0, 0, 0, 0), "rot_left_to_up");
    tick(2);
    c = cyc;
    joystick[0] = 1'b1;
    push(c + 1, '0, "rot_socd_up_down");
    tick(2);
    c = cyc;
    joystick = '0;
    rotate   = 1'b0;
    push(c + 1, '0, "rot_clear");
    tick(2);

    // Player 1 keys require plain codes
    c = cyc;
    ps2_ev(1'b1, 1'b1, 8'h2B);
    for (int k = 1; k <= 3; k++) push(c + k, '0, "p1_ext_ignored");
    tick(3);
    c = cyc;
    ps2_ev(1'b1, 1'b0, 8'h2B);
    push(c + 2, mk(0, 2'b10, 0, 0, 0, 0, 0), "p1_kb_down");
    tick(3);
    c = cyc;
    ps2_ev(1'b0, 1'b0, 8'h2B);
    push(c + 2, '0, "p1_kb_down_rel");
    tick(3);

    // Player 1 joystick up+left+right: left/right cancel, up passes
    c = cyc;
    joystick[19:16] = 4'b1011;
    push(c + 1, mk(2'b10, 0, 0, 0, 0, 0, 0), "p1_joy_socd_lr");
    tick(2);
    c = cyc;
    joystick = '0;
    push(c + 1, '0, "p1_joy_clear");
    tick(2);

    // Two fire keys ORed
    c = cyc;
    ps2_ev(1'b1, 1'b0, 8'h29);
    push(c + 2, mk(0, 0, 0, 0, 2'b01, 0, 0), "fire_space");
    tick(3);
    c = cyc;
    ps2_ev(1'b1, 1'b0, 8'h14);
    push(c + 2, mk(0, 0, 0, 0, 2'b01, 0, 0), "fire_both");
    tick(3);
    c = cyc;
    ps2_ev(1'b0, 1'b0, 8'h29);
    push(c + 2, mk(0, 0, 0, 0, 2'b01, 0, 0), "fire_ctrl_holds");
    tick(3);
    c = cyc;
    ps2_ev(1'b0, 1'b0, 8'h14);
    push(c + 1, mk(0, 0, 0, 0, 2'b01, 0, 0), "fire_ctrl_rel_lat1");
    push(c + 2, '0, "fire_all_released");
    tick(3);

    // Alternate start key
    c = cyc;
    ps2_ev(1'b1, 1'b0, 8'h05);
    push(c + 2, mk(0, 0, 0, 0, 0, 2'b01, 0), "start0_alt");
    tick(3);
    c = cyc;
    ps2_ev(1'b0, 1'b0, 8'h05);
    push(c + 2, '0, "start0_rel");
    tick(3);

    // Keyboard coin: pulse, ignored re-press, held, release, second pulse
    c = cyc;
    for (int k = 1; k <= 34; k++) begin
      logic on;
      on = ((k >= 2) && (k <= 9)) || ((k >= 25) && (k <= 32));
      push(c + k, mk(0, 0, 0, 0, 0, 0, on ? 2'b01 : 2'b00), $sformatf("coin0_k%0d", k));
    end
    ps2_ev(1'b1, 1'b0, 8'h2E);
    tick(3);
    ps2_ev(1'b0, 1'b0, 8'h2E);
    tick(2);
    ps2_ev(1'b1, 1'b0, 8'h2E);
    tick(16);
    ps2_ev(1'b0, 1'b0, 8'h2E);
    tick(2);
    ps2_ev(1'b1, 1'b0, 8'h2E);
    tick(11);
    ps2_ev(1'b0, 1'b0, 8'h2E);
    tick(3);

    // Joystick coin for player 1: 1-cycle latency, held without retrigger
    c = cyc;
    joystick[22] = 1'b1;
    for (int k = 1; k <= 10; k++)
      push(c + k, mk(0, 0, 0, 0, 0, 0, (k <= 8) ? 2'b10 : 2'b00), $sformatf("coin1_joy_k%0d", k));
    tick(10);
    joystick = '0;
    tick(2);

    // Autofire on player 1, then disabled while held
    c = cyc;
    autofire_en = 2'b10;
    ps2_ev(1'b1, 1'b0, 8'h1C);
    push(c + 1, '0, "af_lat1");
    for (int unsigned n = c + 2; n <= c + 18; n++)
      push(n, mk(0, 0, 0, 0, {phase_after(n - 1), 1'b0}, 0, 0), $sformatf("af_on_c%0d", n));
    for (int unsigned n = c + 19; n <= c + 22; n++)
      push(n, mk(0, 0, 0, 0, 2'b10, 0, 0), "af_off_steady");
    tick(18);
    autofire_en = '0;
    tick(5);
    c = cyc;
    ps2_ev(1'b0, 1'b0, 8'h1C);
    push(c + 1, mk(0, 0, 0, 0, 2'b10, 0, 0), "af_rel_lat1");
    push(c + 2, '0, "af_released");
    tick(3);

    for (int i = 0; i < 100 && q_cyc.size() != 0; i++) tick(1);
    if (q_cyc.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q_cyc.size());
    end

    // Asynchronous reset must drop an active coin pulse at once
    joystick[6] = 1'b1;
    tick(3);
    checks++;
    if (coin !== 2'b01) begin
      errors++;
      $display("FAIL coin_before_reset: got %b want 01", coin);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (coin !== 2'b00) begin
      errors++;
      $display("FAIL coin_async_reset: got %b want 00", coin);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
- Parametrised successor to the per-core inline PS/2 key decoder and joystick merge logic.
- Converts `hps_io` `ps2_key` events and per-player joystick words into registered per-player arcade controls.
- Adds optional 90° control rotation, opposite-direction cleaning, coin pulse stretching and per-player autofire.
- Sits between `hps_io` and the game core in the `emu` top.

Parameters:
- NUM_PLAYERS, 2, number of player channels (1..4); keyboard maps players 0 and 1 only.
- COIN_PULSE_CYCLES, 1200000, coin output width in clk_sys cycles (100 ms at 12 MHz); must be ≥1.
- AUTOFIRE_DIV, 200000, clk_sys cycles per autofire phase half-period; must be ≥1.
- SOCD_CLEAN, 1, 1 = opposite directions both active resolve to neither.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_key  in  11  [10] toggle per event, [9] pressed, [8] extended, [7:0] scancode.
- joystick  in  16*NUM_PLAYERS  player p in bits [16p+15:16p]; bit0 right, 1 left, 2 down, 3 up, 4 fire, 5 start, 6 coin.
- rotate  in  1  1 = remap directions for a horizontally-rotated monitor.
- autofire_en  in  NUM_PLAYERS  per-player autofire enable.
- up, down, left, right, fire  out  NUM_PLAYERS each  active-high controls.
- start  out  NUM_PLAYERS  active-high start.
- coin  out  NUM_PLAYERS  stretched coin pulse.

Behaviour:
- Reset: all outputs 0; all key-state registers 0; coin counters 0; autofire divider 0; autofire phase 1; toggle register 0; `armed` flag 0.
- Event detect:
  - First clock after reset release: `tog_q <= ps2_key[10]`, set `armed`; no event is produced.
  - Afterwards, an event occurs when `armed` and `ps2_key[10] != tog_q`.
  - On an event, the matched key register is loaded with `ps2_key[9]` on the same edge.
  - Unmatched codes are ignored.
- Key map (`e` = extended bit [8]):
  - Player 0 directions, ignoring `e`: up 0x75, down 0x72, left 0x6B, right 0x74.
  - Player 0 fire, `e`=0: 0x29 or 0x14. Start0: 0x16 or 0x05. Coin0: 0x2E.
  - Player 1, `e`=0: up 0x2D, down 0x2B, left 0x23, right 0x34, fire 0x1C. Start1: 0x1E or 0x06. Coin1: 0x36.
  - Two keys sharing one control use separate registers that are ORed, so releasing one key does not cancel the other.
- Merge: raw control = keyboard state OR joystick bit, per player.
- Rotate: when `rotate`=1, up = raw left, down = raw right, left = raw down, right = raw up. When 0, straight through.
- SOCD: applied after rotation. Up&down both 1 → both 0; left&right both 1 → both 0.
- Autofire:
  - The divider counts 0..AUTOFIRE_DIV-1; the phase toggles on each wrap.
  - fire = raw fire & (autofire_en[p] ? phase : 1).
- Coin stretcher, per player:
  - A rising edge of raw coin while the counter is 0 loads COIN_PULSE_CYCLES; coin = (counter != 0).
  - Counter decrements each cycle.
  - Edges during an active pulse are ignored. Holding coin does not extend or retrigger; release is required before the next pulse.
- Latency:
  - ps2 toggle → key register: 1 cycle. Key register → output: 1 cycle, so 2 cycles total.
  - joystick → output: 1 cycle.
  - Coin output rises 1 cycle after the raw rising edge is registered.
- Reset mid-pulse: coin drops immediately (asynchronous).
- Players ≥2: joystick only; their keyboard terms are 0.

Decomposition:
- Package `arcade_input_pkg`: scancode localparams, joystick bit-index constants, typedef `ctrl_t` {up, down, left, right, fire, start, coin}.
- Sub-module `coin_pulse_stretcher` (parameter WIDTH_CYCLES), generated once per player.

Test Plan:
- Reset release with ps2_key[10]=1 → no event; all outputs stay 0.
- Toggle ps2_key {pressed=1, e=1, 0x75}, rotate=0 → up[0]=1 exactly 2 cycles later; release event → up[0]=0 two cycles after.
- rotate=1, joystick[1] (P0 left)=1 → up[0]=1 after 1 cycle, left[0]=0; add joystick[0] (right)=1 with SOCD_CLEAN=1 → up[0]=down[0]=0.
- Press space and ctrl, release space → fire[0] remains 1; release ctrl → fire[0]=0.
- COIN_PULSE_CYCLES=8: press '5' and hold 20 cycles → coin[0] high exactly 8 cycles, once; a second press during the pulse is ignored; release then press → second 8-cycle pulse.
- AUTOFIRE_DIV=4, autofire_en[1]=1, hold A → fire[1] toggles every 4 cycles; autofire_en[1]=0 → steady 1.
